// File: rtl/seg_capture_decoder.sv
// Captures a multiplexed 4-digit 7-segment display and decodes it to hex nibbles.
// Latency: STABLE_CYCLES+2 clocks from a stable pin change; there is no backpressure.
module seg_capture_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  input  logic        clear,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        err,
  output logic [1:0]  err_digit
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [6:0]  seg_meta;
  logic [6:0]  seg_sync;
  logic [3:0]  an_meta;
  logic [3:0]  an_sync;
  logic [10:0] prev_sample;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [7:0]  cnt_inc;
  logic [3:0]  seen;
  logic [3:0]  seen_upd;
  logic        single;
  logic        same;
  logic        accept;
  logic [1:0]  digit_idx;
  logic        legal;
  logic [3:0]  nibble;

  // Both pin groups are asynchronous to clk; idle (all-ones) is the safe reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_meta <= '1;
      seg_sync <= '1;
      an_meta  <= '1;
      an_sync  <= '1;
    end else begin
      seg_meta <= seg_n;
      seg_sync <= seg_meta;
      an_meta  <= an_n;
      an_sync  <= an_meta;
    end
  end

  always_comb begin
    single    = 1'b1;
    digit_idx = 2'd0;
    case (an_sync)
      4'b1110: digit_idx = 2'd0;
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg_sync)
      7'b0000001: nibble = 4'h0;
      7'b1001111: nibble = 4'h1;
      7'b0010010: nibble = 4'h2;
      7'b0000110: nibble = 4'h3;
      7'b1001100: nibble = 4'h4;
      7'b0100100: nibble = 4'h5;
      7'b0100000: nibble = 4'h6;
      7'b0001111: nibble = 4'h7;
      7'b0000000: nibble = 4'h8;
      7'b0000100: nibble = 4'h9;
      7'b0000010: nibble = 4'hA;
      7'b1100000: nibble = 4'hB;
      7'b0110001: nibble = 4'hC;
      7'b1000010: nibble = 4'hD;
      7'b0010000: nibble = 4'hE;
      7'b0111000: nibble = 4'hF;
      default:    legal  = 1'b0;
    endcase
  end

  assign same    = ({an_sync, seg_sync} == prev_sample);
  assign cnt_inc = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 8'd1;

  // HELD with an unchanged sample never re-accepts; every other single-anode path may.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (!single) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        ST_TRACK: cnt_nxt = same ? cnt_inc : 8'd1;
        ST_HELD:  cnt_nxt = same ? cnt : 8'd1;
        default:  cnt_nxt = 8'd1;
      endcase
      if (state == ST_HELD && same) begin
        state_nxt = ST_HELD;
      end else if (cnt_nxt == CNT_MAX) begin
        accept    = 1'b1;
        state_nxt = ST_HELD;
      end else begin
        state_nxt = ST_TRACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      prev_sample <= '1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      prev_sample <= {an_sync, seg_sync};
    end
  end

  assign seen_upd = seen | ~an_sync;

  // Clear outranks an acceptance on the same edge; value is only ever changed by legal digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      value       <= 16'h0000;
      digit_valid <= 4'h0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_digit   <= 2'd0;
      seen        <= 4'h0;
    end else begin
      frame_valid <= 1'b0;
      if (clear) begin
        err         <= 1'b0;
        err_digit   <= 2'd0;
        digit_valid <= 4'h0;
        seen        <= 4'h0;
      end else if (accept && legal) begin
        value[{digit_idx, 2'b00} +: 4] <= nibble;
        digit_valid[digit_idx]         <= 1'b1;
        if (seen_upd == 4'hF) begin
          frame_valid <= 1'b1;
          seen        <= 4'h0;
        end else begin
          seen <= seen_upd;
        end
      end else if (accept) begin
        err                    <= 1'b1;
        err_digit              <= digit_idx;
        digit_valid[digit_idx] <= 1'b0;
        seen                   <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Scoreboard bench: a run-length reference model predicts every output change and its clock edge.
module tb_seg_capture_decoder;

  localparam int N = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0010000, 7'b0111000
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dv;
    logic        fv;
    logic        err;
    logic [1:0]  errd;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err;
  logic [1:0]  err_digit;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int frames   = 0;
  int frames0;

  exp_t  exp_q[$];
  exp_t  got_e;
  snap_t mon_snap;
  snap_t mon_last = '0;

  snap_t       m      = '0;
  snap_t       m_last = '0;
  logic [3:0]  m_seen = 4'h0;
  int          m_run  = 0;
  int          m_edge = 0;
  logic [10:0] m_prev = '1;
  logic [10:0] m_h0   = '1;
  logic [10:0] m_h1   = '1;

  logic [3:0] r_an;
  logic [6:0] r_seg;
  int         r_len;

  always #5 clk = ~clk;

  seg_capture_decoder #(.STABLE_CYCLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clear       (clear),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err         (err),
    .err_digit   (err_digit)
  );

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (SEG_TAB[i] == s) return i;
    return -1;
  endfunction

  // Model: a digit is accepted when a run of identical single-anode samples reaches length N.
  // Samples reach the decision logic two clocks after the pins are driven.
  task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic c, input logic r);
    logic [10:0] samp;
    logic [3:0]  nseen;
    int          k;
    int          nib;
    exp_t        e;
    m_edge++;
    m.fv = 1'b0;
    if (r) begin
      m      = '0;
      m_seen = 4'h0;
      m_run  = 0;
      m_prev = '1;
      m_h0   = '1;
      m_h1   = '1;
    end else begin
      samp = m_h1;
      m_h1 = m_h0;
      m_h0 = {a, s};
      k = -1;
      if ($countones(samp[10:7]) == 3)
        for (int i = 0; i < 4; i++) if (!samp[7+i]) k = i;
      if (k < 0) m_run = 0;
      else if (samp == m_prev) m_run++;
      else m_run = 1;
      m_prev = samp;
      if (c) begin
        m.err  = 1'b0;
        m.errd = 2'd0;
        m.dv   = 4'h0;
        m_seen = 4'h0;
      end else if (k >= 0 && m_run == N) begin
        nib = decode(samp[6:0]);
        if (nib >= 0) begin
          m.value[4*k +: 4] = 4'(nib);
          m.dv[k] = 1'b1;
          nseen = m_seen | (4'b0001 << k);
          if (nseen == 4'hF) begin
            m.fv   = 1'b1;
            m_seen = 4'h0;
          end else begin
            m_seen = nseen;
          end
        end else begin
          m.err   = 1'b1;
          m.errd  = 2'(k);
          m.dv[k] = 1'b0;
          m_seen  = 4'h0;
        end
      end
    end
    if (m != m_last) begin
      e.cyc = m_edge;
      e.s   = m;
      exp_q.push_back(e);
    end
    m_last = m;
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic c, input logic r);
    an_n  = a;
    seg_n = s;
    clear = c;
    rst   = r;
    model_edge(a, s, c, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    mon_snap = {value, digit_valid, frame_valid, err, err_digit};
    if (frame_valid === 1'b1) frames++;
    if (mon_snap !== mon_last) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected edge=%0d got=%h", edges, mon_snap);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.cyc != edges || got_e.s !== mon_snap) begin
          failures++;
          $display("FAIL scoreboard_compare edge=%0d got=%h expected edge=%0d value=%h",
                   edges, mon_snap, got_e.cyc, got_e.s);
        end
      end
    end
    mon_last = mon_snap;
  end

  initial begin
    repeat (3) step(4'hF, 7'h7F, 1'b0, 1'b1);
    check("reset_value", 32'(value), 32'h0);
    check("reset_digit_valid", 32'(digit_valid), 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_err_digit", 32'(err_digit), 32'h0);

    // Single digit 3 on digit 0: update lands on the sixth edge.
    repeat (2) step(4'hF, 7'h7F, 1'b0, 1'b0);
    repeat (5) step(4'b1110, 7'b0000110, 1'b0, 1'b0);
    check("latency_dv0_early", 32'(digit_valid[0]), 32'h0);
    step(4'b1110, 7'b0000110, 1'b0, 1'b0);
    check("latency_value0", 32'(value[3:0]), 32'h3);
    check("latency_dv0", 32'(digit_valid[0]), 32'h1);
    repeat (10) step(4'b1110, 7'b0000110, 1'b0, 1'b0);
    check("held_value", 32'(value), 32'h0003);

    // Full frame 1, A, 0, F.
    step(4'b1110, 7'b0000110, 1'b1, 1'b0);
    frames0 = frames;
    step(4'hF, 7'h7F, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      r_an  = ~(4'b0001 << d);
      r_seg = (d == 0) ? SEG_TAB[1] : (d == 1) ? SEG_TAB[10] : (d == 2) ? SEG_TAB[0] : SEG_TAB[15];
      repeat (8) step(r_an, r_seg, 1'b0, 1'b0);
    end
    repeat (4) step(4'hF, 7'h7F, 1'b0, 1'b0);
    check("frame_value", 32'(value), 32'hF0A1);
    check("frame_pulses", 32'(frames - frames0), 32'd1);

    // Illegal pattern on digit 1.
    frames0 = frames;
    repeat (8) step(4'b1101, 7'h7F, 1'b0, 1'b0);
    check("illegal_err", 32'(err), 32'h1);
    check("illegal_err_digit", 32'(err_digit), 32'h1);
    check("illegal_dv1", 32'(digit_valid[1]), 32'h0);
    check("illegal_no_frame", 32'(frames - frames0), 32'd0);
    step(4'b1101, 7'h7F, 1'b1, 1'b0);
    check("clear_err", 32'(err), 32'h0);
    check("clear_keeps_value", 32'(value), 32'hF0A1);

    // Unstable segments and non-single anodes never accept.
    for (int t = 0; t < 8; t++)
      repeat (3) step(4'b1110, (t % 2 == 1) ? SEG_TAB[2] : SEG_TAB[5], 1'b0, 1'b0);
    check("toggle_no_accept", 32'(digit_valid), 32'h0);
    repeat (10) step(4'b1100, SEG_TAB[8], 1'b0, 1'b0);
    repeat (10) step(4'b1111, SEG_TAB[8], 1'b0, 1'b0);
    check("multi_anode_no_accept", 32'(digit_valid), 32'h0);
    check("multi_anode_no_err", 32'(err), 32'h0);

    // Clear on the acceptance edge discards the digit.
    repeat (5) step(4'b1110, SEG_TAB[7], 1'b0, 1'b0);
    step(4'b1110, SEG_TAB[7], 1'b1, 1'b0);
    repeat (4) step(4'b1110, SEG_TAB[7], 1'b0, 1'b0);
    check("clear_wins_dv", 32'(digit_valid), 32'h0);
    check("clear_wins_value", 32'(value), 32'hF0A1);

    // Reset in the middle of tracking a new digit.
    repeat (3) step(4'b1011, SEG_TAB[9], 1'b0, 1'b0);
    step(4'b1011, SEG_TAB[9], 1'b0, 1'b1);
    check("midtrack_rst_value", 32'(value), 32'h0);
    check("midtrack_rst_dv", 32'(digit_valid), 32'h0);
    check("midtrack_rst_err", 32'(err), 32'h0);

    for (int b = 0; b < 300; b++) begin
      r_an  = ($urandom_range(0, 9) < 7) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      r_seg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : SEG_TAB[$urandom_range(0, 15)];
      r_len = int'($urandom_range(1, 9));
      for (int i = 0; i < r_len; i++)
        step(r_an, r_seg, ($urandom_range(0, 40) == 0), ($urandom_range(0, 400) == 0));
    end

    repeat (4) step(4'hF, 7'h7F, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
